// File: rtl/spi_rom_responder.sv
// SPI mode-0 serial-flash READ responder: oversampled CS/SCLK/MOSI, byte memory read port, MISO stream.
// Latency: last address rise -> mem_rd 1 clk -> holding byte 1 clk; no stalls, since SCLK phases of >=4 clk absorb the fetch.
module spi_rom_responder #(
  parameter int         ADDR_BITS   = 24,
  parameter logic [7:0] READ_CMD    = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_data,
  output logic                 busy,
  output logic                 bad_cmd
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_n_s, sclk_s, mosi_s, cs_act;
  logic                   cs_act_q, sclk_dly_q;
  logic                   rise, fall;

  state_t                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             cmd_sr_q, cmd_sr_d;
  logic [22:0]            addr_sr_q, addr_sr_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             out_sr_q, out_sr_d;
  logic [7:0]             hold_q, hold_d;
  logic                   oe_q, oe_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   rd_dly_q, rd_dly_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic                   bad_cmd_q, bad_cmd_d;
  logic [7:0]             cmd_next;
  logic [23:0]            addr_next;

  // The CS synchroniser resets to "selected" and cs_act_q to 1, so a CS that is
  // already low when reset is released never looks like a transaction start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_act_q    <= 1'b1;
      sclk_dly_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_act_q    <= cs_act;
      sclk_dly_q  <= sclk_s;
    end
  end

  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_act = ~cs_n_s;
  assign rise   = sclk_s & ~sclk_dly_q;
  assign fall   = ~sclk_s & sclk_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      cmd_sr_q   <= '0;
      addr_sr_q  <= '0;
      bit_idx_q  <= '0;
      out_sr_q   <= '0;
      hold_q     <= '0;
      oe_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      mem_addr_q <= '0;
      bad_cmd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_sr_q   <= cmd_sr_d;
      addr_sr_q  <= addr_sr_d;
      bit_idx_q  <= bit_idx_d;
      out_sr_q   <= out_sr_d;
      hold_q     <= hold_d;
      oe_q       <= oe_d;
      mem_rd_q   <= mem_rd_d;
      rd_dly_q   <= rd_dly_d;
      mem_addr_q <= mem_addr_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_sr_d   = cmd_sr_q;
    addr_sr_d  = addr_sr_q;
    bit_idx_d  = bit_idx_q;
    out_sr_d   = out_sr_q;
    oe_d       = oe_q;
    mem_rd_d   = 1'b0;
    rd_dly_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    bad_cmd_d  = 1'b0;
    hold_d     = rd_dly_q ? mem_data : hold_q;
    cmd_next   = {cmd_sr_q, mosi_s};
    addr_next  = {addr_sr_q, mosi_s};

    if (!cs_act) begin
      // Deselect aborts everything, including a fetch that is still in flight.
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      bit_idx_d = '0;
      out_sr_d  = '0;
      oe_d      = 1'b0;
      rd_dly_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!cs_act_q) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_sr_d  = cmd_next[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (cmd_next == READ_CMD) begin
                state_d = S_ADDR;
              end else begin
                bad_cmd_d = 1'b1;
                state_d   = S_IGNORE;
              end
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_sr_d = addr_next[22:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              bit_idx_d  = '0;
              state_d    = S_DATA;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_next[ADDR_BITS-1:0];
            end
          end
        end
        S_DATA: begin
          if (fall) begin
            oe_d      = 1'b1;
            bit_idx_d = bit_idx_q + 3'd1;
            out_sr_d  = (bit_idx_q == 3'd0) ? hold_q : {out_sr_q[6:0], 1'b0};
            // Bit 0 is now on the wire: prefetch the next byte well before its first fall.
            if (bit_idx_q == 3'd7) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = mem_addr_q + ADDR_BITS'(1);
            end
          end
        end
        S_IGNORE: begin
          oe_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign spi_miso    = oe_q & out_sr_q[7];
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign bad_cmd     = bad_cmd_q;

endmodule
